// File: rtl/regfile_mp_if.sv
// Bus bundle between issue/writeback logic and the multi-port register file.
// Carries read ports, write ports, scoreboard allocate/flush and busy count.
// master = pipeline side (drives addresses/data), slave = register file.
interface regfile_mp_if #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int NR    = 2,
  parameter int NW    = 2
);
  localparam int AW = $clog2(NREGS);

  logic [NR*AW-1:0]   raddr;
  logic [NR*XLEN-1:0] rdata;
  logic [NR-1:0]      rbusy;
  logic [NW-1:0]      wen;
  logic [NW*AW-1:0]   waddr;
  logic [NW*XLEN-1:0] wdata;
  logic               alloc_en;
  logic [AW-1:0]      alloc_addr;
  logic               flush;
  logic [AW:0]        busy_cnt;

  modport master (
    output raddr, wen, waddr, wdata, alloc_en, alloc_addr, flush,
    input  rdata, rbusy, busy_cnt
  );

  modport slave (
    input  raddr, wen, waddr, wdata, alloc_en, alloc_addr, flush,
    output rdata, rbusy, busy_cnt
  );
endinterface

// File: rtl/regfile_mp.sv
// Multi-port integer register file (r0 hardwired to zero) with per-register busy scoreboard.
// Reads combinational (zero latency); writes and scoreboard updates take effect on the next edge.
// No backpressure: every request is accepted each cycle; busy bits tell issue when to stall.
// Ports: clk, rst (async active-high), bus (regfile_mp_if.slave: read/write ports, alloc, flush, busy_cnt).
// Optional feature: define REGFILE_BYPASS_EN for same-cycle write-to-read forwarding.
module regfile_mp #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int NR    = 2,
  parameter int NW    = 2
) (
  input  logic         clk,
  input  logic         rst,
  regfile_mp_if.slave  bus
);
  localparam int AW = $clog2(NREGS);

  logic [XLEN-1:0]    regs_q [NREGS];
  logic [NREGS-1:0]   busy_q, busy_d;
  logic [AW:0]        busy_cnt_q, busy_cnt_d;
  logic [NR*XLEN-1:0] rdata_d;
  logic [NR-1:0]      rbusy_d;
  logic [AW-1:0]      ra_d;
  logic [XLEN-1:0]    rd_d;
  logic               rb_d;

  // Register data. Loop order makes the highest-index write port win on collisions.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < NREGS; k++) regs_q[k] <= '0;
    end else begin
      for (int j = 0; j < NW; j++) begin
        if (bus.wen[j] && bus.waddr[j*AW +: AW] != '0)
          regs_q[bus.waddr[j*AW +: AW]] <= bus.wdata[j*XLEN +: XLEN];
      end
    end
  end

  // Scoreboard next state: writeback clears, allocate sets afterwards so it wins,
  // flush overrides both. Count is taken from the next state so it tracks busy exactly.
  always_comb begin
    busy_d = busy_q;
    for (int j = 0; j < NW; j++) begin
      if (bus.wen[j]) busy_d[bus.waddr[j*AW +: AW]] = 1'b0;
    end
    if (bus.alloc_en) busy_d[bus.alloc_addr] = 1'b1;
    busy_d[0] = 1'b0;
    if (bus.flush) busy_d = '0;

    busy_cnt_d = '0;
    for (int k = 0; k < NREGS; k++)
      busy_cnt_d = busy_cnt_d + {{AW{1'b0}}, busy_d[k]};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q     <= '0;
      busy_cnt_q <= '0;
    end else begin
      busy_q     <= busy_d;
      busy_cnt_q <= busy_cnt_d;
    end
  end

  // Read ports.
  always_comb begin
    rdata_d = '0;
    rbusy_d = '0;
    ra_d    = '0;
    rd_d    = '0;
    rb_d    = 1'b0;
    for (int i = 0; i < NR; i++) begin
      ra_d = bus.raddr[i*AW +: AW];
      rd_d = (ra_d == '0) ? '0 : regs_q[ra_d];
      rb_d = busy_q[ra_d];
`ifdef REGFILE_BYPASS_EN
      // Forward in-flight write data; the writeback also retires the busy bit
      // unless an allocate to the same register re-marks it this cycle.
      for (int j = 0; j < NW; j++) begin
        if (bus.wen[j] && bus.waddr[j*AW +: AW] == ra_d && ra_d != '0) begin
          rd_d = bus.wdata[j*XLEN +: XLEN];
          if (!(bus.alloc_en && bus.alloc_addr == ra_d)) rb_d = 1'b0;
        end
      end
`endif
      rdata_d[i*XLEN +: XLEN] = rd_d;
      rbusy_d[i]              = rb_d;
    end
  end

  assign bus.rdata    = rdata_d;
  assign bus.rbusy    = rbusy_d;
  assign bus.busy_cnt = busy_cnt_q;
endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: directed scenarios plus randomized traffic against an array/flag model.
// Inputs change 1 time unit after each rising edge; outputs are sampled before the next edge.
// Summary line reports passed/total comparisons.
module tb_regfile_mp;
  localparam int XLEN = 32;
  localparam int NREGS = 32;
  localparam int NR = 2;
  localparam int NW = 2;
  localparam int AW = 5;

  logic clk;
  logic rst;
  int checks;
  int passes;

  logic [XLEN-1:0] mregs [NREGS];
  bit              mbusy [NREGS];

  regfile_mp_if #(.XLEN(XLEN), .NREGS(NREGS), .NR(NR), .NW(NW)) bus ();

  regfile_mp #(.XLEN(XLEN), .NREGS(NREGS), .NR(NR), .NW(NW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic model_clear();
    for (int k = 0; k < NREGS; k++) begin
      mregs[k] = '0;
      mbusy[k] = 1'b0;
    end
  endtask

  task automatic idle();
    bus.wen        = '0;
    bus.waddr      = '0;
    bus.wdata      = '0;
    bus.alloc_en   = 1'b0;
    bus.alloc_addr = '0;
    bus.flush      = 1'b0;
  endtask

  task automatic set_rd(input int p, input int a);
    bus.raddr[p*AW +: AW] = AW'(a);
  endtask

  task automatic set_wr(input int p, input int a, input logic [XLEN-1:0] d);
    bus.wen[p]              = 1'b1;
    bus.waddr[p*AW +: AW]   = AW'(a);
    bus.wdata[p*XLEN +: XLEN] = d;
  endtask

  // Advance one edge, applying the architectural rules to the model using the inputs present at the edge.
  task automatic cycle();
    int a;
    @(posedge clk);
    if (!rst) begin
      for (int j = 0; j < NW; j++) begin
        a = int'(bus.waddr[j*AW +: AW]);
        if (bus.wen[j]) begin
          if (a != 0) mregs[a] = bus.wdata[j*XLEN +: XLEN];
          mbusy[a] = 1'b0;
        end
      end
      if (bus.alloc_en && bus.alloc_addr != '0) mbusy[bus.alloc_addr] = 1'b1;
      if (bus.flush) for (int k = 0; k < NREGS; k++) mbusy[k] = 1'b0;
    end
    #1;
  endtask

  function automatic logic [XLEN-1:0] exp_rd(input int a);
    logic [XLEN-1:0] v;
    v = (a == 0) ? '0 : mregs[a];
`ifdef REGFILE_BYPASS_EN
    for (int j = 0; j < NW; j++)
      if (a != 0 && bus.wen[j] && int'(bus.waddr[j*AW +: AW]) == a) v = bus.wdata[j*XLEN +: XLEN];
`endif
    return v;
  endfunction

  function automatic logic exp_rb(input int a);
    logic b;
    b = mbusy[a];
`ifdef REGFILE_BYPASS_EN
    for (int j = 0; j < NW; j++)
      if (a != 0 && bus.wen[j] && int'(bus.waddr[j*AW +: AW]) == a &&
          !(bus.alloc_en && int'(bus.alloc_addr) == a)) b = 1'b0;
`endif
    return b;
  endfunction

  function automatic int exp_cnt();
    int n;
    n = 0;
    for (int k = 0; k < NREGS; k++) if (mbusy[k]) n++;
    return n;
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    idle();
    bus.raddr = '0;
    set_rd(0, 5);
    model_clear();
    #2;
    checks++;
    if (bus.busy_cnt !== '0) $display("FAIL reset_cnt got %0d want 0", bus.busy_cnt);
    else passes++;
    checks++;
    if (bus.rdata[0 +: XLEN] !== '0) $display("FAIL reset_rdata got %h want 0", bus.rdata[0 +: XLEN]);
    else passes++;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    // Mid-run reset: load r5 and a busy bit, then reset between edges.
    set_wr(0, 5, 32'hDEADBEEF);
    bus.alloc_en = 1'b1;
    bus.alloc_addr = 5'd4;
    cycle();
    idle();
    #1;
    checks++;
    if (bus.rdata[0 +: XLEN] !== 32'hDEADBEEF) $display("FAIL pre_reset_r5 got %h want deadbeef", bus.rdata[0 +: XLEN]);
    else passes++;
    checks++;
    if (bus.busy_cnt !== 6'd1) $display("FAIL pre_reset_cnt got %0d want 1", bus.busy_cnt);
    else passes++;
    #2;
    rst = 1'b1;
    model_clear();
    #1;
    checks++;
    if (bus.rdata[0 +: XLEN] !== '0) $display("FAIL async_reset_r5 got %h want 0", bus.rdata[0 +: XLEN]);
    else passes++;
    checks++;
    if (bus.busy_cnt !== '0) $display("FAIL async_reset_cnt got %0d want 0", bus.busy_cnt);
    else passes++;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_r0();
    idle();
    set_wr(0, 0, 32'h12345678);
    bus.alloc_en = 1'b1;
    bus.alloc_addr = '0;
    set_rd(0, 0);
    cycle();
    idle();
    #1;
    checks++;
    if (bus.rdata[0 +: XLEN] !== '0) $display("FAIL r0_data got %h want 0", bus.rdata[0 +: XLEN]);
    else passes++;
    checks++;
    if (bus.rbusy[0] !== 1'b0) $display("FAIL r0_busy got %b want 0", bus.rbusy[0]);
    else passes++;
    checks++;
    if (bus.busy_cnt !== '0) $display("FAIL r0_cnt got %0d want 0", bus.busy_cnt);
    else passes++;
  endtask

  task automatic test_write_collision();
    idle();
    set_wr(0, 7, 32'hA);
    set_wr(1, 7, 32'hB);
    set_rd(1, 7);
    cycle();
    idle();
    #1;
    checks++;
    if (bus.rdata[XLEN +: XLEN] !== 32'hB) $display("FAIL collision_r7 got %h want 0000000b", bus.rdata[XLEN +: XLEN]);
    else passes++;
  endtask

  task automatic test_alloc_writeback();
    idle();
    set_rd(0, 3);
    bus.alloc_en = 1'b1;
    bus.alloc_addr = 5'd3;
    cycle();
    idle();
    #1;
    checks++;
    if (bus.rbusy[0] !== 1'b1) $display("FAIL alloc_r3_busy got %b want 1", bus.rbusy[0]);
    else passes++;
    checks++;
    if (bus.busy_cnt !== 6'd1) $display("FAIL alloc_r3_cnt got %0d want 1", bus.busy_cnt);
    else passes++;
    set_wr(1, 3, 32'h33);
    bus.alloc_en = 1'b1;
    bus.alloc_addr = 5'd3;
    cycle();
    idle();
    #1;
    checks++;
    if (bus.rbusy[0] !== 1'b1) $display("FAIL alloc_wb_busy got %b want 1", bus.rbusy[0]);
    else passes++;
    checks++;
    if (bus.busy_cnt !== 6'd1) $display("FAIL alloc_wb_cnt got %0d want 1", bus.busy_cnt);
    else passes++;
    set_wr(0, 3, 32'h34);
    cycle();
    idle();
    #1;
    checks++;
    if (bus.rbusy[0] !== 1'b0 || bus.busy_cnt !== '0)
      $display("FAIL wb_release got busy=%b cnt=%0d want busy=0 cnt=0", bus.rbusy[0], bus.busy_cnt);
    else passes++;
  endtask

  task automatic test_flush();
    int a;
    for (int n = 0; n < 3; n++) begin
      a = (n == 0) ? 1 : (n == 1) ? 2 : 4;
      idle();
      bus.alloc_en = 1'b1;
      bus.alloc_addr = AW'(a);
      cycle();
    end
    idle();
    #1;
    checks++;
    if (bus.busy_cnt !== 6'd3) $display("FAIL flush_pre_cnt got %0d want 3", bus.busy_cnt);
    else passes++;
    bus.flush = 1'b1;
    bus.alloc_en = 1'b1;
    bus.alloc_addr = 5'd6;
    set_wr(0, 10, 32'hF00D);
    cycle();
    idle();
    set_rd(0, 6);
    set_rd(1, 10);
    #1;
    checks++;
    if (bus.busy_cnt !== '0) $display("FAIL flush_cnt got %0d want 0", bus.busy_cnt);
    else passes++;
    checks++;
    if (bus.rbusy !== 2'b00) $display("FAIL flush_rbusy got %b want 00", bus.rbusy);
    else passes++;
    checks++;
    if (bus.rdata[XLEN +: XLEN] !== 32'hF00D) $display("FAIL flush_write_r10 got %h want 0000f00d", bus.rdata[XLEN +: XLEN]);
    else passes++;
  endtask

  task automatic test_bypass();
    logic [XLEN-1:0] want_d;
    logic            want_b;
    idle();
    set_wr(0, 9, 32'h11);
    bus.alloc_en = 1'b1;
    bus.alloc_addr = 5'd9;
    cycle();
    idle();
    set_wr(1, 9, 32'h55);
    set_rd(0, 9);
    #1;
`ifdef REGFILE_BYPASS_EN
    want_d = 32'h55;
    want_b = 1'b0;
`else
    want_d = 32'h11;
    want_b = 1'b1;
`endif
    checks++;
    if (bus.rdata[0 +: XLEN] !== want_d) $display("FAIL bypass_same_cycle_data got %h want %h", bus.rdata[0 +: XLEN], want_d);
    else passes++;
    checks++;
    if (bus.rbusy[0] !== want_b) $display("FAIL bypass_same_cycle_busy got %b want %b", bus.rbusy[0], want_b);
    else passes++;
    cycle();
    idle();
    #1;
    checks++;
    if (bus.rdata[0 +: XLEN] !== 32'h55 || bus.rbusy[0] !== 1'b0)
      $display("FAIL bypass_next_cycle got data=%h busy=%b want data=00000055 busy=0", bus.rdata[0 +: XLEN], bus.rbusy[0]);
    else passes++;
  endtask

  task automatic test_random();
    int a;
    int errs;
    errs = 0;
    for (int it = 0; it < 300; it++) begin
      idle();
      for (int j = 0; j < NW; j++)
        if ($urandom_range(0, 1) == 1) set_wr(j, int'($urandom_range(0, 7)), $urandom);
      bus.alloc_en = ($urandom_range(0, 2) != 0);
      bus.alloc_addr = AW'($urandom_range(0, 7));
      bus.flush = ($urandom_range(0, 15) == 0);
      for (int p = 0; p < NR; p++) set_rd(p, int'($urandom_range(0, 9)));
      #1;
      for (int p = 0; p < NR; p++) begin
        a = int'(bus.raddr[p*AW +: AW]);
        checks++;
        if (bus.rdata[p*XLEN +: XLEN] !== exp_rd(a) || bus.rbusy[p] !== exp_rb(a)) begin
          if (errs < 10)
            $display("FAIL rand_read it=%0d port=%0d addr=%0d got %h/%b want %h/%b",
                     it, p, a, bus.rdata[p*XLEN +: XLEN], bus.rbusy[p], exp_rd(a), exp_rb(a));
          errs++;
        end else passes++;
      end
      cycle();
      checks++;
      if (bus.busy_cnt !== 6'(exp_cnt())) begin
        if (errs < 10) $display("FAIL rand_cnt it=%0d got %0d want %0d", it, bus.busy_cnt, exp_cnt());
        errs++;
      end else passes++;
    end
  endtask

  initial begin
    checks = 0;
    passes = 0;
    test_reset();
    test_r0();
    test_write_collision();
    test_alloc_writeback();
    test_flush();
    test_bypass();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
